// File: rtl/dv_tb_pkg.sv
// Shared definitions for the test-status mailbox and its consumers.
// Holds the mailbox FSM state type, the register offsets inside the
// 16-byte window, and the default pass/fail codes. Firmware headers and the
// end-of-test monitor use the same code values.
package dv_tb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Register index = addr[3:2]
    localparam logic [1:0] STATUS  = 2'd0;
    localparam logic [1:0] CHAR    = 2'd1;
    localparam logic [1:0] SCRATCH = 2'd2;
    localparam logic [1:0] CYCLES  = 2'd3;

    localparam logic [31:0] DEF_PASS_CODE = 32'hC001_C0DE;
    localparam logic [31:0] DEF_FAIL_CODE = 32'hDEAD_BEEF;

endpackage

// File: rtl/dv_test_status_mbox.sv
// Test-status mailbox: a bus responder that firmware writes a pass or fail
// code into. After the first code it drains for DRAIN_CYCLES cycles, then
// raises testEnd (and testFail if any fail code was seen) for the end-of-test
// monitor.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req/we/addr/be/wdata bus request (gnt = req, never stalls)
//   gnt                 request accepted (combinational)
//   rvalid/rdata/err    registered response, one cycle after accept
//   char_valid/char_data one-cycle console byte pulse from CHAR writes
//   testEnd/testFail    end-of-test vectors, only driven in DONE
module dv_test_status_mbox
    import dv_tb_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h8F00_0000,
    parameter int unsigned       DRAIN_CYCLES = 16,
    parameter logic [31:0]       PASS_CODE    = DEF_PASS_CODE,
    parameter logic [31:0]       FAIL_CODE    = DEF_FAIL_CODE,
    parameter int                N_OUT        = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic              gnt,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              char_valid,
    output logic [7:0]        char_data,
    output logic [N_OUT-1:0]  testEnd,
    output logic [N_OUT-1:0]  testFail
);

    // Wide enough to hold DRAIN_CYCLES-1
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic               r_fail_q;
    logic               r_bad_code;
    logic [7:0]         r_scratch [4];
    logic [31:0]        r_cycles;
    logic               r_rvalid;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic               r_char_valid;
    logic [7:0]         r_char_data;

    logic               w_accept;
    logic               w_hit;
    logic [1:0]         w_reg;
    logic               w_status_wr;
    logic               w_pass_evt;
    logic               w_fail_evt;
    logic               w_bad_evt;
    logic               w_scratch_wr;
    logic               w_char_wr;
    logic [31:0]        w_rdata;
    logic [1:0]         w_unused_addr_lsbs;

    // While reset is held nothing is accepted, so a request coinciding with
    // reset never produces a response.
    assign w_accept     = req & ~rst;
    assign gnt          = w_accept;
    assign w_hit        = (addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
    assign w_reg        = addr[3:2];
    assign w_unused_addr_lsbs = addr[1:0];

    assign w_status_wr  = w_accept & we & w_hit & (w_reg == STATUS);
    assign w_pass_evt   = w_status_wr & (be == 4'hF) & (wdata == PASS_CODE);
    assign w_fail_evt   = w_status_wr & (be == 4'hF) & (wdata == FAIL_CODE);
    assign w_bad_evt    = w_status_wr & ~(w_pass_evt | w_fail_evt);
    assign w_scratch_wr = w_accept & we & w_hit & (w_reg == SCRATCH);
    assign w_char_wr    = w_accept & we & w_hit & (w_reg == CHAR) & be[0];

    // Read mux; writes and misses return zero.
    always_comb begin
        w_rdata = '0;
        if (w_hit && !we) begin
            case (w_reg)
                STATUS:  w_rdata = {29'b0, r_bad_code, r_fail_q, (r_state == DONE)};
                CHAR:    w_rdata = '0;
                SCRATCH: w_rdata = {r_scratch[3], r_scratch[2], r_scratch[1], r_scratch[0]};
                CYCLES:  w_rdata = r_cycles;
                default: w_rdata = '0;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_next;
    end

    // FSM: next state. Only the first code starts the drain; later codes
    // only affect fail_q.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_pass_evt || w_fail_evt)
                    w_state_next = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (r_drain_cnt == '0) w_state_next = DONE;
            end
            DONE:    w_state_next = DONE;
            default: w_state_next = RUN;
        endcase
    end

    // FSM: outputs. testFail is gated by DONE so the monitor never sees a
    // fail before the end edge.
    always_comb begin
        testEnd  = {N_OUT{r_state == DONE}};
        testFail = {N_OUT{(r_state == DONE) && r_fail_q}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state == RUN && (w_pass_evt || w_fail_evt)) begin
            r_drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
        end else if (r_state == DRAIN && r_drain_cnt != '0) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fail_q   <= 1'b0;
            r_bad_code <= 1'b0;
            r_cycles   <= '0;
        end else begin
            r_cycles <= r_cycles + 1'b1;
            if (w_fail_evt) r_fail_q   <= 1'b1;
            if (w_bad_evt)  r_bad_code <= 1'b1;
        end
    end

    // One register per scratch byte so each lane has a single driver.
    for (genvar gi = 0; gi < 4; gi++) begin : g_scratch
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_scratch[gi] <= '0;
            else if (w_scratch_wr && be[gi])
                r_scratch[gi] <= wdata[gi*8 +: 8];
        end
    end

    // Registered response path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_char_valid <= 1'b0;
            r_char_data  <= '0;
        end else begin
            r_rvalid     <= w_accept;
            r_err        <= w_accept & ~w_hit;
            r_rdata      <= w_accept ? w_rdata : 32'h0;
            r_char_valid <= w_char_wr;
            if (w_char_wr) r_char_data <= wdata[7:0];
        end
    end

    assign rvalid     = r_rvalid;
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign char_valid = r_char_valid;
    assign char_data  = r_char_data;

endmodule

// File: tb/tb_dv_test_status_mbox.sv
// Bench for dv_test_status_mbox: table of single accesses with expected
// responses, plus hand sequences for drain timing, fail-during-drain,
// async reset mid-drain, console bytes and a zero-drain instance.
module tb_dv_test_status_mbox;
    import dv_tb_pkg::*;

    localparam logic [31:0] BASE = 32'h8F00_0000;
    localparam logic [31:0] PASS = 32'hC001_C0DE;
    localparam logic [31:0] FAIL_C = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req0 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;

    logic        gnt, rvalid, err, char_valid;
    logic [31:0] rdata;
    logic [7:0]  char_data;
    logic [0:0]  test_end, test_fail;

    logic        gnt0, rvalid0, err0, char_valid0;
    logic [31:0] rdata0;
    logic [7:0]  char_data0;
    logic [0:0]  test_end0, test_fail0;

    dv_test_status_mbox #(.DRAIN_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
        .char_valid(char_valid), .char_data(char_data),
        .testEnd(test_end), .testFail(test_fail)
    );

    dv_test_status_mbox #(.DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .be(be),
        .wdata(wdata), .gnt(gnt0), .rvalid(rvalid0), .rdata(rdata0), .err(err0),
        .char_valid(char_valid0), .char_data(char_data0),
        .testEnd(test_end0), .testFail(test_fail0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] tag;
    } resp_t;
    resp_t exp_q[$];
    resp_t cur;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
    } vec_t;
    vec_t vt[16];

    // Edges since reset release; a CYCLES read returns this value as it
    // stands when the request is driven.
    logic [31:0] tb_cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop an expected response on every rvalid; flag missing
    // and unexpected responses.
    always @(negedge clk) begin
        if (!rst) begin
            if (req) check("gnt", 32'(gnt), 32'd1);
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (t=%0t)", $time);
                end else begin
                    cur = exp_q.pop_front();
                    check("rdata", rdata, cur.rdata);
                    check("err", 32'(err), 32'(cur.err));
                    $display("txn t=%0t rdata=%h err=%0b exp_rdata=%h exp_err=%0b",
                             $time, rdata, err, cur.rdata, cur.err);
                end
            end else if (exp_q.size() != 0 && exp_q[0].tag < tb_cyc) begin
                total++;
                bad++;
                $display("FAIL missing_rvalid: got rvalid=0 expected response (t=%0t)", $time);
                void'(exp_q.pop_front());
            end
        end
    end

    // Drive one access for one cycle; called right after a posedge.
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] er, input logic ee);
        resp_t e;
        e.rdata = er;
        e.err   = ee;
        e.tag   = tb_cyc;
        exp_q.push_back(e);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Checks testEnd/testFail at the negedge of cycles T+from .. T+to;
    // testEnd must first appear at T+to.
    task automatic wait_end(input int from, input int to, input logic exp_fail);
        for (int i = from; i <= to; i++) begin
            @(negedge clk);
            check($sformatf("testEnd@T+%0d", i), 32'(test_end), 32'(i == to));
            check($sformatf("testFail@T+%0d", i), 32'(test_fail), 32'((i == to) && exp_fail));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vt[0]  = '{1'b0, BASE + 32'h20, 4'hF, 32'h0,         32'h0,         1'b1};
        vt[1]  = '{1'b1, BASE + 32'h08, 4'h2, 32'hAABB_CCDD, 32'h0,         1'b0};
        vt[2]  = '{1'b0, BASE + 32'h08, 4'hF, 32'h0,         32'h0000_CC00, 1'b0};
        vt[3]  = '{1'b1, BASE + 32'h08, 4'h9, 32'h1122_3344, 32'h0,         1'b0};
        vt[4]  = '{1'b0, BASE + 32'h08, 4'hF, 32'h0,         32'h1100_CC44, 1'b0};
        vt[5]  = '{1'b0, BASE + 32'h04, 4'hF, 32'h0,         32'h0,         1'b0};
        vt[6]  = '{1'b0, BASE + 32'h00, 4'hF, 32'h0,         32'h0,         1'b0};
        vt[7]  = '{1'b1, BASE + 32'h00, 4'hF, 32'h1234_5678, 32'h0,         1'b0};
        vt[8]  = '{1'b0, BASE + 32'h03, 4'hF, 32'h0,         32'h4,         1'b0};
        vt[9]  = '{1'b1, BASE + 32'h00, 4'h3, PASS,          32'h0,         1'b0};
        vt[10] = '{1'b0, BASE + 32'h00, 4'hF, 32'h0,         32'h4,         1'b0};
        vt[11] = '{1'b1, BASE + 32'h0C, 4'hF, 32'h0,         32'h0,         1'b0};
        vt[12] = '{1'b1, BASE + 32'h40, 4'hF, PASS,          32'h0,         1'b1};
        vt[13] = '{1'b1, BASE + 32'h10, 4'hF, FAIL_C,        32'h0,         1'b1};
        vt[14] = '{1'b0, BASE + 32'h00, 4'hF, 32'h0,         32'h4,         1'b0};
        vt[15] = '{1'b0, BASE + 32'h0B, 4'hF, 32'h0,         32'h1100_CC44, 1'b0};

        // Reset state, with a request held during reset (must not be granted)
        req = 1'b1; we = 1'b0; addr = BASE;
        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_char_valid", 32'(char_valid), 32'd0);
        check("rst_char_data", 32'(char_data), 32'd0);
        check("rst_testEnd", 32'(test_end), 32'd0);
        check("rst_testFail", 32'(test_fail), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        req = 1'b0; addr = '0;
        rst = 1'b0;

        // Table vectors, issued back to back
        for (int i = 0; i < 16; i++)
            bus(vt[i].w, vt[i].a, vt[i].b, vt[i].d, vt[i].er, vt[i].ee);
        idle(2);

        // Free-running counter, two back-to-back reads
        bus(1'b0, BASE + 32'h0C, 4'hF, 32'h0, tb_cyc, 1'b0);
        bus(1'b0, BASE + 32'h0C, 4'hF, 32'h0, tb_cyc, 1'b0);
        idle(1);

        // Console byte
        bus(1'b1, BASE + 32'h04, 4'h1, 32'h1234_5641, 32'h0, 1'b0);
        @(negedge clk);
        check("char_valid_pulse", 32'(char_valid), 32'd1);
        check("char_data", 32'(char_data), 32'h41);
        @(negedge clk);
        check("char_valid_one_cycle", 32'(char_valid), 32'd0);
        @(posedge clk); #1;
        bus(1'b1, BASE + 32'h04, 4'hE, 32'h0000_0042, 32'h0, 1'b0);
        @(negedge clk);
        check("char_be0_clear", 32'(char_valid), 32'd0);
        check("char_data_hold", 32'(char_data), 32'h41);
        @(posedge clk); #1;

        // Bad code recorded earlier; a valid PASS still completes
        bus(1'b1, BASE, 4'hF, PASS, 32'h0, 1'b0);
        wait_end(1, 17, 1'b0);
        bus(1'b0, BASE, 4'hF, 32'h0, 32'h5, 1'b0);
        // Fail code in DONE still raises testFail
        bus(1'b1, BASE, 4'hF, FAIL_C, 32'h0, 1'b0);
        @(negedge clk);
        check("done_fail_testFail", 32'(test_fail), 32'd1);
        check("done_fail_testEnd", 32'(test_end), 32'd1);
        @(posedge clk); #1;
        bus(1'b0, BASE, 4'hF, 32'h0, 32'h7, 1'b0);
        idle(2);

        // FAIL code
        do_reset();
        bus(1'b1, BASE, 4'hF, FAIL_C, 32'h0, 1'b0);
        wait_end(1, 17, 1'b1);
        bus(1'b0, BASE, 4'hF, 32'h0, 32'h3, 1'b0);
        idle(2);

        // PASS, then FAIL five cycles later during drain; end time unchanged
        do_reset();
        bus(1'b1, BASE, 4'hF, PASS, 32'h0, 1'b0);
        idle(4);
        bus(1'b1, BASE, 4'hF, FAIL_C, 32'h0, 1'b0);
        wait_end(6, 17, 1'b1);
        bus(1'b0, BASE, 4'hF, 32'h0, 32'h3, 1'b0);
        idle(2);

        // Async reset mid-drain while a response is on the bus
        do_reset();
        bus(1'b1, BASE, 4'hF, PASS, 32'h0, 1'b0);
        idle(4);
        bus(1'b0, BASE, 4'hF, 32'h0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rvalid", 32'(rvalid), 32'd0);
        check("async_rdata", rdata, 32'd0);
        check("async_testEnd", 32'(test_end), 32'd0);
        exp_q.delete();
        req = 1'b1; we = 1'b0; addr = BASE;
        #1;
        check("rst_req_gnt", 32'(gnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        req = 1'b0; addr = '0;
        rst = 1'b0;
        bus(1'b0, BASE, 4'hF, 32'h0, 32'h0, 1'b0);
        bus(1'b1, BASE, 4'hF, PASS, 32'h0, 1'b0);
        wait_end(1, 17, 1'b0);
        bus(1'b0, BASE, 4'hF, 32'h0, 32'h1, 1'b0);
        idle(2);

        // Zero drain: testEnd rises one cycle after the accepting edge
        we = 1'b1; addr = BASE; be = 4'hF; wdata = PASS; req0 = 1'b1;
        @(negedge clk);
        check("drain0_before", 32'(test_end0), 32'd0);
        @(posedge clk); #1;
        req0 = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        @(negedge clk);
        check("drain0_testEnd", 32'(test_end0), 32'd1);
        check("drain0_testFail", 32'(test_fail0), 32'd0);
        check("drain0_rvalid", 32'(rvalid0), 32'd1);
        @(posedge clk); #1;

        idle(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
